// File: rtl/simple_dma_controller_pkg.sv
// rtl/simple_dma_controller_pkg.sv - state encodings and constants shared by the DMA responder
package simple_dma_controller_pkg;

    // One-hot FSM encodings, one bit per state
    localparam logic [7:0] ST_IDLE     = 8'b0000_0001;
    localparam logic [7:0] ST_CHECK    = 8'b0000_0010;
    localparam logic [7:0] ST_WAIT_DEV = 8'b0000_0100;
    localparam logic [7:0] ST_ACCESS   = 8'b0000_1000;
    localparam logic [7:0] ST_RESP     = 8'b0001_0000;
    localparam logic [7:0] ST_ACK      = 8'b0010_0000;
    localparam logic [7:0] ST_DONE     = 8'b0100_0000;
    localparam logic [7:0] ST_ERR      = 8'b1000_0000;

    // Byte write enables for a full 16-bit word
    localparam logic [1:0]  DMA_WE_WORD    = 2'b11;
    // Byte-address step between consecutive words
    localparam logic [15:0] ADDR_INC       = 16'd2;
    // Highest word-aligned byte address; stepping past it wraps
    localparam logic [15:0] ADDR_LAST_WORD = 16'hFFFE;

endpackage

// File: rtl/simple_dma_controller_wdg.sv
// rtl/simple_dma_controller_wdg.sv - device-acknowledge timeout watchdog
//
// Counts cycles while enabled; expire is high on the cycle the count reaches
// TIMEOUT_CYCLES-1. clear forces the count back to zero.
// Ports: clk, reset_n (async, active-low), enable, clear, expire.
module dma_timeout_wdg #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int unsigned   CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign expire = enable && (count_q == LAST);

    // Saturates at LAST so a held enable cannot roll the count over
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expire) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/simple_dma_controller.sv
// rtl/simple_dma_controller.sv - responder between a DMA peripheral and the core DMA master port
//
// Accepts a block request (start byte address, word count, direction), runs one
// 16-bit access per word and returns each word with a one-cycle dma_ack.
// Optional feature macro: SIMPLE_DMA_TIMEOUT_EN (dev_ack watchdog -> ERR).
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   dma_rqst, dma_rd_wr              request level, direction (1 = memory read)
//   dma_start_address, dma_num_words transfer descriptor, sampled in IDLE only
//   dev_ack, dev_out, dev_in         device handshake and data
//   dma_ack, dma_end_flag, dma_error_flag  per-word ack, completion, failure
//   dma_addr, dma_din, dma_en, dma_we, dma_priority  core master request
//   dma_dout, dma_ready, dma_resp    core master response
module simple_dma_controller
    import simple_dma_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic        PRIORITY       = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic        dev_ack,
    input  logic [15:0] dev_out,
    output logic [15:0] dev_in,
    output logic        dma_ack,
    output logic        dma_end_flag,
    output logic        dma_error_flag,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    output logic        dma_priority,
    input  logic [15:0] dma_dout,
    input  logic        dma_ready,
    input  logic        dma_resp
);

    logic [7:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rd_wr_q, rd_wr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        tmo_expire;
    logic        st_wait;

    assign st_wait = (state_q == ST_WAIT_DEV);

`ifdef SIMPLE_DMA_TIMEOUT_EN
    // The watchdog only counts in WAIT_DEV and restarts on every exit
    dma_timeout_wdg #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdg (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (st_wait),
        .clear   (!st_wait),
        .expire  (tmo_expire)
    );
`else
    // No watchdog: WAIT_DEV waits indefinitely; the parameter stays in the
    // interface so both builds share one instantiation.
    assign tmo_expire = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // All outputs decode from state or registers only
    assign dma_en         = (state_q == ST_ACCESS);
    assign dma_addr       = dma_en ? addr_q[15:1] : 15'd0;
    assign dma_we         = (dma_en && !rd_wr_q) ? DMA_WE_WORD : 2'b00;
    assign dma_din        = dma_en ? wdata_q : 16'd0;
    assign dma_ack        = (state_q == ST_ACK);
    assign dev_in         = rdata_q;
    assign dma_end_flag   = (state_q == ST_DONE);
    assign dma_error_flag = (state_q == ST_ERR);
    assign dma_priority   = PRIORITY;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rd_wr_d = rd_wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (dma_rqst) begin
                    addr_d  = dma_start_address;
                    cnt_d   = dma_num_words;
                    rd_wr_d = dma_rd_wr;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!dma_rqst) begin
                    state_d = ST_IDLE;
                end else if (addr_q[0]) begin
                    state_d = ST_ERR;
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_DEV;
                end
            end
            ST_WAIT_DEV: begin
                if (!dma_rqst) begin
                    state_d = ST_IDLE;
                end else if (dev_ack) begin
                    if (!rd_wr_q) begin
                        wdata_d = dev_out;
                    end
                    state_d = ST_ACCESS;
                end else if (tmo_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_ACCESS: begin
                // An accepted access always completes, even if the request dropped
                if (dma_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!dma_rqst) begin
                    state_d = ST_IDLE;
                end else if (dma_resp) begin
                    state_d = ST_ERR;
                end else begin
                    if (rd_wr_q) begin
                        rdata_d = dma_dout;
                    end
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                cnt_d  = cnt_q - 16'd1;
                addr_d = addr_q + ADDR_INC;
                if (!dma_rqst) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 16'd1) begin
                    state_d = ST_DONE;
                end else if (addr_q == ADDR_LAST_WORD) begin
                    // Further words would wrap the 64 KiB space
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_WAIT_DEV;
                end
            end
            ST_DONE, ST_ERR: begin
                if (!dma_rqst) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 16'd0;
            cnt_q   <= 16'd0;
            rd_wr_q <= 1'b0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rd_wr_q <= rd_wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_simple_dma_controller.sv
// tb/tb_simple_dma_controller.sv - self-checking bench for simple_dma_controller
module tb_simple_dma_controller;

    localparam int unsigned TMO = 8;

    logic        clk;
    logic        reset_n;
    logic        dma_rqst;
    logic        dma_rd_wr;
    logic [15:0] dma_start_address;
    logic [15:0] dma_num_words;
    logic        dev_ack;
    logic [15:0] dev_out;
    logic [15:0] dev_in;
    logic        dma_ack;
    logic        dma_end_flag;
    logic        dma_error_flag;
    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic        dma_priority;
    logic [15:0] dma_dout;
    logic        dma_ready;
    logic        dma_resp;

    simple_dma_controller #(
        .TIMEOUT_CYCLES (TMO),
        .PRIORITY       (1'b1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .dma_rqst          (dma_rqst),
        .dma_rd_wr         (dma_rd_wr),
        .dma_start_address (dma_start_address),
        .dma_num_words     (dma_num_words),
        .dev_ack           (dev_ack),
        .dev_out           (dev_out),
        .dev_in            (dev_in),
        .dma_ack           (dma_ack),
        .dma_end_flag      (dma_end_flag),
        .dma_error_flag    (dma_error_flag),
        .dma_addr          (dma_addr),
        .dma_din           (dma_din),
        .dma_en            (dma_en),
        .dma_we            (dma_we),
        .dma_priority      (dma_priority),
        .dma_dout          (dma_dout),
        .dma_ready         (dma_ready),
        .dma_resp          (dma_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory seen by the DUT and the reference image the bench expects
    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];

    bit          mem_stall    = 1'b0;
    int          mem_wait_max = 0;
    int          mem_err_idx  = -1;
    int          acc_count    = 0;
    int          wait_left    = 0;
    bit          pend         = 1'b0;
    logic [15:0] pend_data    = 16'd0;
    bit          pend_err     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core-side memory: accepts after a random number of wait cycles,
    // returns data/response in the following cycle
    initial begin
        dma_ready = 1'b0;
        dma_resp  = 1'b0;
        dma_dout  = 16'd0;
        forever begin
            @(negedge clk);
            dma_ready = 1'b0;
            dma_resp  = 1'b0;
            if (pend) begin
                dma_dout = pend_data;
                dma_resp = pend_err;
                pend     = 1'b0;
            end
            if (reset_n && dma_en && !mem_stall) begin
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    dma_ready = 1'b1;
                    if (dma_we == 2'b11) mem[dma_addr] = dma_din;
                    pend_data = mem[dma_addr];
                    pend_err  = (acc_count == mem_err_idx);
                    pend      = 1'b1;
                    acc_count++;
                    wait_left = $urandom_range(mem_wait_max);
                end
            end
        end
    end

    // One complete transfer: device behaviour is either dev_ack held high
    // (hold) or single pulses after a random gap; extra_ack adds a stray
    // pulse in each dma_ack cycle that must not start the next word.
    task automatic run_xfer(input logic rw, input logic [15:0] addr, input int n,
                            input bit hold, input int gap_max, input bit extra_ack,
                            input int err_word, input int mwait, input bit fixed);
        int          base, avail, words_ok, exp_acks, exp_acc, acks, cyc, gap;
        int          first_en, last_ack;
        bit          exp_err, armed, offered, prev_en, fin, lat_mode;
        logic [15:0] wd [$];

        base  = int'(addr[15:1]);
        avail = 32768 - base;
        if (addr[0]) begin
            exp_err = 1'b1; exp_acks = 0; exp_acc = 0;
        end else if (n == 0) begin
            exp_err = 1'b0; exp_acks = 0; exp_acc = 0;
        end else begin
            words_ok = (n < avail) ? n : avail;
            if (err_word >= 0 && err_word < words_ok) begin
                exp_err = 1'b1; exp_acks = err_word; exp_acc = err_word + 1;
            end else begin
                exp_err = (n > avail); exp_acks = words_ok; exp_acc = words_ok;
            end
        end
        lat_mode = hold && (mwait == 0) && !addr[0] && (n > 0);

        wd.delete();
        for (int k = 0; k < n; k++) begin
            if (fixed) wd.push_back(16'h1234 + 16'(k) * 16'h4444);
            else       wd.push_back(16'($urandom));
        end

        mem_wait_max = mwait;
        mem_err_idx  = err_word;
        acc_count    = 0;
        wait_left    = $urandom_range(mwait);

        @(negedge clk);
        dma_rd_wr         = rw;
        dma_start_address = addr;
        dma_num_words     = 16'(n);
        dma_rqst          = 1'b1;
        dev_ack           = hold;
        dev_out           = (n > 0) ? wd[0] : 16'($urandom);
        gap      = 2 + $urandom_range(gap_max);
        armed    = 1'b1;
        offered  = hold;
        acks     = 0;
        cyc      = 0;
        first_en = -1;
        last_ack = -1;
        prev_en  = 1'b0;
        fin      = 1'b0;

        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            // Descriptor inputs are only sampled at the start
            dma_start_address = 16'($urandom);
            dma_num_words     = 16'($urandom);
            dma_rd_wr         = 1'($urandom);

            if (dma_en && !prev_en) begin
                check("en_after_dev_ack", 32'(offered), 32'd1);
                offered = hold;
                if (first_en < 0) first_en = cyc;
            end
            if (dma_en) begin
                check("dma_addr", 32'(dma_addr), 32'(base + acks));
                check("dma_we", 32'(dma_we), rw ? 32'd0 : 32'd3);
                if (!rw && acks < n) check("dma_din", 32'(dma_din), 32'(wd[acks]));
            end
            prev_en = dma_en;

            if (dma_ack) begin
                if (rw) check("dev_in", 32'(dev_in), 32'(ref_mem[base + acks]));
                if (lat_mode && last_ack >= 0) check("word_latency", 32'(cyc - last_ack), 32'd4);
                last_ack = cyc;
                acks++;
            end
            if (dma_end_flag || dma_error_flag) fin = 1'b1;

            if (hold) begin
                dev_ack = 1'b1;
                if (acks < n) dev_out = wd[acks];
            end else begin
                dev_ack = 1'b0;
                if (dma_ack) begin
                    armed = 1'b1;
                    gap   = 1 + $urandom_range(gap_max);
                    if (extra_ack) begin
                        dev_ack = 1'b1;
                        dev_out = 16'($urandom);
                    end
                end else if (armed) begin
                    gap--;
                    if (gap == 0) begin
                        dev_ack = 1'b1;
                        dev_out = (acks < n) ? wd[acks] : 16'($urandom);
                        armed   = 1'b0;
                        offered = 1'b1;
                    end
                end
            end
        end

        check("xfer_finished", 32'(fin), 32'd1);
        check("end_flag", 32'(dma_end_flag), 32'(!exp_err));
        check("error_flag", 32'(dma_error_flag), 32'(exp_err));
        check("ack_count", 32'(acks), 32'(exp_acks));
        check("access_count", 32'(acc_count), 32'(exp_acc));
        if (addr[0] || n == 0) check("flag_latency", 32'(cyc), 32'd2);
        if (lat_mode) check("first_en_latency", 32'(first_en), 32'd3);
        if (!rw) begin
            for (int k = 0; k < exp_acc; k++) ref_mem[base + k] = wd[k];
            for (int k = 0; k < exp_acc; k++) check("mem_written", 32'(mem[base + k]), 32'(ref_mem[base + k]));
        end

        dev_ack = 1'b0;
        @(negedge clk);
        check("flag_level", 32'({dma_end_flag, dma_error_flag}), 32'({!exp_err, exp_err}));
        dma_rqst = 1'b0;
        @(negedge clk);
        check("flags_clear", 32'({dma_end_flag, dma_error_flag, dma_ack}), 32'd0);
    endtask

    initial begin
        int          k, acks_seen, flags_seen, cyc, n, gmax, errw;
        bit          rw, hold, extra;
        logic [15:0] addr;

        reset_n           = 1'b0;
        dma_rqst          = 1'b0;
        dma_rd_wr         = 1'b0;
        dma_start_address = 16'd0;
        dma_num_words     = 16'd0;
        dev_ack           = 1'b0;
        dev_out           = 16'd0;
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 3; i++) begin
            mem[16'h0100 + i]     = 16'hA001 + 16'(i);
            ref_mem[16'h0100 + i] = 16'hA001 + 16'(i);
        end

        repeat (3) @(negedge clk);
        check("rst_en", 32'(dma_en), 32'd0);
        check("rst_ack", 32'(dma_ack), 32'd0);
        check("rst_flags", 32'({dma_end_flag, dma_error_flag}), 32'd0);
        check("rst_addr", 32'(dma_addr), 32'd0);
        check("rst_we_din", 32'({dma_we, dma_din}), 32'd0);
        check("rst_dev_in", 32'(dev_in), 32'd0);
        check("rst_priority", 32'(dma_priority), 32'd1);
        reset_n = 1'b1;

        // Directed cases
        run_xfer(1'b1, 16'h0200, 3, 1'b1, 0, 1'b0, -1, 0, 1'b0);
        run_xfer(1'b0, 16'h0300, 2, 1'b0, 2, 1'b0, -1, 0, 1'b1);
        run_xfer(1'b1, 16'h0400, 0, 1'b1, 0, 1'b0, -1, 0, 1'b0);
        run_xfer(1'b0, 16'h0201, 2, 1'b1, 0, 1'b0, -1, 0, 1'b0);
        run_xfer(1'b1, 16'h0800, 4, 1'b1, 0, 1'b0, 1, 1, 1'b0);
        run_xfer(1'b1, 16'hFFFC, 3, 1'b1, 0, 1'b0, -1, 0, 1'b0);
        run_xfer(1'b0, 16'hFFFC, 2, 1'b0, 1, 1'b1, -1, 0, 1'b0);
        run_xfer(1'b1, 16'h0A00, 3, 1'b0, 3, 1'b1, -1, 2, 1'b0);

        // Request dropped while the access is stalled
        mem_stall = 1'b1; mem_wait_max = 0; wait_left = 0; mem_err_idx = -1; acc_count = 0;
        @(negedge clk);
        dma_rd_wr = 1'b1; dma_start_address = 16'h0500; dma_num_words = 16'd3;
        dma_rqst = 1'b1; dev_ack = 1'b1;
        k = 0;
        while (!dma_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("drop_en_seen", 32'(dma_en), 32'd1);
        dma_rqst = 1'b0; dev_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("drop_en_held", 32'(dma_en), 32'd1);
        check("drop_addr_held", 32'(dma_addr), 32'h280);
        mem_stall = 1'b0;
        acks_seen = 0; flags_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (dma_ack) acks_seen++;
            if (dma_end_flag || dma_error_flag) flags_seen++;
        end
        check("drop_no_ack", 32'(acks_seen), 32'd0);
        check("drop_no_flag", 32'(flags_seen), 32'd0);
        check("drop_access_done", 32'(acc_count), 32'd1);
        check("drop_idle_en", 32'(dma_en), 32'd0);

        // Reset asserted in the middle of an access
        mem_stall = 1'b1;
        @(negedge clk);
        dma_rd_wr = 1'b1; dma_start_address = 16'h0402; dma_num_words = 16'd4;
        dma_rqst = 1'b1; dev_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_en_before", 32'(dma_en), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_en", 32'(dma_en), 32'd0);
        check("rstmid_addr_we", 32'({dma_addr, dma_we}), 32'd0);
        check("rstmid_misc", 32'({dma_ack, dma_end_flag, dma_error_flag, dma_din, dev_in}), 32'd0);
        dma_rqst = 1'b0; dev_ack = 1'b0; mem_stall = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Device never acknowledges
        mem_err_idx = -1;
        @(negedge clk);
        dma_rd_wr = 1'b1; dma_start_address = 16'h0600; dma_num_words = 16'd2;
        dma_rqst = 1'b1; dev_ack = 1'b0;
`ifdef SIMPLE_DMA_TIMEOUT_EN
        cyc = 0;
        while (!dma_error_flag && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_flag", 32'(dma_error_flag), 32'd1);
        check("timeout_latency", 32'(cyc), 32'(TMO + 2));
`else
        repeat (40) @(negedge clk);
        check("no_timeout_flag", 32'(dma_error_flag), 32'd0);
        check("no_timeout_en", 32'(dma_en), 32'd0);
`endif
        dma_rqst = 1'b0;
        @(negedge clk);
        check("nodev_idle", 32'({dma_end_flag, dma_error_flag, dma_en}), 32'd0);

        // Randomized transfers
        for (int t = 0; t < 24; t++) begin
            rw   = 1'($urandom);
            n    = $urandom_range(6);
            k    = $urandom_range(9);
            if (k == 0)      addr = 16'($urandom) | 16'h0001;
            else if (k == 1) addr = 16'hFFFE - 16'(2 * $urandom_range(4));
            else             addr = 16'($urandom) & 16'hFFFE;
            hold  = 1'($urandom);
            gmax  = $urandom_range(3);
            extra = !hold && 1'($urandom);
            errw  = ($urandom_range(4) == 0) ? int'($urandom_range(3)) : -1;
            run_xfer(rw, addr, n, hold, gmax, extra, errw, $urandom_range(3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
